// File: rtl/data_memory_sized.sv
// Byte-addressed data RAM with sized MIPS loads/stores behind a valid/ready request channel.
// Loads return after LATENCY cycles; stores and rejected accesses answer after one cycle.
module data_memory_sized #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata
);
    localparam int unsigned DEPTH     = 2 ** (ADDR_W - 2);
    localparam int unsigned PIPE_N    = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int unsigned PIPE_LAST = PIPE_N - 1;
    localparam logic [1:0]  CNT_INIT  = 2'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            state;
    logic [1:0]        count;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       pipe [PIPE_N];

    logic              accept;
    logic              bad_size;
    logic              misaligned;
    logic              out_of_range;
    logic              err;
    logic              load_ok;
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       rd_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_val;
    logic [3:0]        byte_en;
    logic [31:0]       wr_data;

    assign req_ready = (state == StIdle) && rst_n;
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[ADDR_W-1:2];
    assign rd_word   = mem[word_idx];

    always_comb begin
        bad_size     = (req_size == 2'b11);
        misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = |req_addr[31:ADDR_W];
        err          = bad_size || misaligned || out_of_range;
        load_ok      = !req_we && !err;
    end

    // Lane extraction and extension, little-endian.
    always_comb begin
        sel_byte = rd_word[{req_addr[1:0], 3'b000} +: 8];
        sel_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_size)
            2'b00:   load_val = {{24{req_signed & sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{req_signed & sel_half[15]}}, sel_half};
            default: load_val = rd_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en = 4'b0000;
        wr_data = 32'h0;
        case (req_size)
            2'b00: begin
                byte_en = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wr_data = req_wdata;
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Free-running delay line; the FSM taps it exactly LATENCY-1 edges after accept.
    always_ff @(posedge clk) begin
        pipe[0] <= load_val;
        for (int i = 1; i < PIPE_N; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            count     <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        if (load_ok && (LATENCY > 1)) begin
                            state <= StWait;
                            count <= CNT_INIT;
                        end else begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err;
                            rsp_rdata <= load_ok ? load_val : 32'h0;
                        end
                    end
                end
                StWait: begin
                    if (count == 2'd0) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pipe[PIPE_LAST];
                    end else begin
                        count <= count - 2'd1;
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: three instances (latency 1, 3, 4) checked against a
// byte-array reference model, directed vector table plus randomized traffic.
module tb_data_memory_sized;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid [3];
    logic        rsp_err [3];
    logic [31:0] rsp_rdata [3];

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned model [1 << AW];

    always #5 clk = ~clk;

    data_memory_sized #(.ADDR_W(AW), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]),
        .rsp_rdata(rsp_rdata[0])
    );
    data_memory_sized #(.ADDR_W(AW), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]),
        .rsp_rdata(rsp_rdata[1])
    );
    data_memory_sized #(.ADDR_W(AW), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[2]), .rsp_err(rsp_err[2]),
        .rsp_rdata(rsp_rdata[2])
    );

    function automatic int lat(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: memory is a plain byte array, accesses are arithmetic over bytes.
    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
               (a >= (32'd1 << AW));
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn,
                                             input logic [31:0] a);
        int          nb;
        logic [31:0] v;
        nb = 1 << sz;
        v  = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(model[int'(a) + i]) << (8 * i));
        if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int nb;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++) model[int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    // Issue one request to all three instances and check every cycle until all are idle.
    task automatic txn(input string name, input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd, input logic exp_err,
                       input logic [31:0] exp_rd);
        int nd;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("%s L%0d ready before", name, lat(d)), 32'(req_ready[d]), 32'd1);
        req_we = we; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = wd;
        for (int d = 0; d < 3; d++) req_valid[d] = 1'b1;
        @(posedge clk);
        if (we && !ref_err(sz, a)) ref_store(sz, a, wd);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                for (int d = 0; d < 3; d++) req_valid[d] = 1'b0;
                req_we = 1'($urandom_range(0, 1));
                req_addr = $urandom;
                req_wdata = $urandom;
            end
            for (int d = 0; d < 3; d++) begin
                nd = (exp_err || we) ? 1 : lat(d);
                check($sformatf("%s L%0d c%0d rsp_valid", name, lat(d), c),
                      32'(rsp_valid[d]), 32'(c == nd));
                check($sformatf("%s L%0d c%0d ready", name, lat(d), c),
                      32'(req_ready[d]), 32'(c > nd));
                if (c == nd) begin
                    check($sformatf("%s L%0d rsp_err", name, lat(d)), 32'(rsp_err[d]),
                          32'(exp_err));
                    check($sformatf("%s L%0d rsp_rdata", name, lat(d)), rsp_rdata[d], exp_rd);
                end
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic        sgn;
        logic        e;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] exp1;
        logic [31:0] exp2;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,  32'h12345680, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEAD80EF};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        1'b0, 32'hFFFFFF80};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        1'b0, 32'h00000080};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        1'b0, 32'hFFFFDEAD};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        1'b0, 32'h000080EF};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h0,   32'h12345678, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        1'b1, 32'h0};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h13,  32'h0000BEEF, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0};
        tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 1'b1, 32'h0};
        tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEAD80EF};
        tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        1'b0, 32'h12345678};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        1'b0, 32'h000000DE};
        tbl[16] = '{1'b0, 2'd0, 1'b1, 32'h10,  32'h0,        1'b0, 32'hFFFFFFEF};
        tbl[17] = '{1'b1, 2'd1, 1'b0, 32'h12,  32'hFFFF1234, 1'b0, 32'h0};
        tbl[18] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'h123480EF};
        tbl[19] = '{1'b0, 2'd1, 1'b1, 32'h2,   32'h0,        1'b0, 32'h00001234};

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            req_valid[d] = 1'b0;
        end
        req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset L%0d rsp_valid", lat(d)), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("reset L%0d rsp_err", lat(d)), 32'(rsp_err[d]), 32'd0);
            check($sformatf("reset L%0d rsp_rdata", lat(d)), rsp_rdata[d], 32'd0);
            check($sformatf("reset L%0d ready", lat(d)), 32'(req_ready[d]), 32'd0);
            rst_n[d] = 1'b1;
        end

        for (int i = 0; i < 20; i++)
            txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sgn, tbl[i].addr,
                tbl[i].wdata, tbl[i].err, tbl[i].rdata);

        // Held valid on the latency-4 instance: one response, re-accept at t+5 with new address.
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10;
        req_valid[2] = 1'b1;
        exp1 = ref_load(2'd2, 1'b0, 32'h10);
        exp2 = ref_load(2'd2, 1'b0, 32'h0);
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("held c%0d rsp_valid", c), 32'(rsp_valid[2]), 32'(c == 4 || c == 9));
            check($sformatf("held c%0d ready", c), 32'(req_ready[2]), 32'(c == 5 || c == 10));
            if (c == 4) check("held first rdata", rsp_rdata[2], exp1);
            if (c == 9) check("held second rdata", rsp_rdata[2], exp2);
            if (c == 1) req_addr = 32'h0;
            if (c == 6) req_valid[2] = 1'b0;
        end

        // Reset mid-read on the latency-3 instance; a prior store must survive.
        txn("pre-reset sw", 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A55A5A, 1'b0, 32'h0);
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        rst_n[1] = 1'b0;
        @(negedge clk);
        check("midrst c1 rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("midrst c1 ready", 32'(req_ready[1]), 32'd0);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("midrst c%0d rsp_valid", c), 32'(rsp_valid[1]), 32'd0);
            if (c == 2) check("midrst c2 ready", 32'(req_ready[1]), 32'd1);
        end
        txn("post-reset lw", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A55A5A);

        // Randomized traffic over a fully written window plus occasional out-of-range addresses.
        for (int w = 0; w < 16; w++)
            txn("init", 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, 32'h0);
        for (int k = 0; k < 150; k++) begin
            we  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
            wd  = $urandom;
            e   = ref_err(sz, a);
            rd  = (e || we) ? 32'h0 : ref_load(sz, sgn, a);
            txn($sformatf("rand%0d", k), we, sz, sgn, a, wd, e, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
